hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: REG_AW, 4, register-address width; 16 architectural registers.
REQ-002 Parameter: MUL_CYCLES, 4, cycles the multiplier occupies EX, including the issue cycle; legal range 2..15.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: id_rs, id_rt  input  REG_AW each  source registers of the instruction in ID.
REQ-006 Port: id_uses_rs, id_uses_rt  input  1 each  the ID instruction actually reads rs/rt.
REQ-007 Port: id_is_mul  input  1  the ID instruction is a multi-cycle multiply.
REQ-008 Port: ex_rd  input  REG_AW  destination register of the instruction in EX.
REQ-009 Port: ex_mem_read  input  1  the EX instruction is a load.
REQ-010 Port: ex_branch_taken  input  1  the EX stage resolved a taken branch.
REQ-011 Port: pc_stall, ifid_stall  output  1 each  hold the PC and the IF/ID register.
REQ-012 Port: idex_bubble  output  1  load a NOP into ID/EX.
REQ-013 Port: ifid_flush  output  1  clear IF/ID to NOP.
REQ-014 Port: ex_hold  output  1  hold the ID/EX register and the multiplier operands.
REQ-015 Port: mul_start  output  1  one-cycle pulse that launches the multiplier.
REQ-016 Port: busy  output  1  FSM is in MUL_BUSY.

Function
REQ-017 Load-use hazard (lu) SHALL be ex_mem_read & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)); register 0 gets no special treatment.
REQ-018 FSM states SHALL be RUN and MUL_BUSY; all outputs are combinational from state and inputs (Mealy); state and counter are registered.
REQ-019 In RUN, priority SHALL be ex_branch_taken > lu > id_is_mul.
REQ-020 RUN with ex_branch_taken: ifid_flush=1 and idex_bubble=1, all other outputs 0; next state RUN; a mul in ID is squashed (no mul_start).
REQ-021 RUN with lu and no branch: pc_stall=ifid_stall=idex_bubble=1; next state RUN; one stall cycle per hazard occurrence.
REQ-022 RUN with id_is_mul, no branch, no lu: mul_start=1, no stalls; next state MUL_BUSY; counter loads MUL_CYCLES-1.
REQ-023 MUL_BUSY: pc_stall=ifid_stall=ex_hold=busy=1, idex_bubble=ifid_flush=mul_start=0; counter decrements each cycle; on counter==1 next state is RUN.
REQ-024 Stall cycles per multiply SHALL equal exactly MUL_CYCLES-1.
REQ-025 In MUL_BUSY, ex_branch_taken, ex_mem_read and id_is_mul SHALL be ignored; hazards are re-evaluated in the first RUN cycle.
REQ-026 Back-to-back multiplies SHALL issue: the first RUN cycle after MUL_BUSY may assert mul_start again.
REQ-027 In RUN with no condition active, all outputs SHALL be 0.

Reset
REQ-028 While rst_n=0: state=RUN, counter=0, all outputs 0; reset asserted mid-MUL_BUSY aborts the multiply immediately.
REQ-029 First edge after reset release SHALL evaluate in RUN.

Configuration
REQ-030 With HAZARD_PERF_EN defined, an output stall_cnt[15:0] SHALL count cycles with pc_stall=1, saturating at 16'hFFFF, cleared by reset; undefined: port and counter absent, all other behaviour identical.

Structure
REQ-031 Package pipe_pkg SHALL hold REG_AW, the hazard_state_t enum (RUN, MUL_BUSY) and a NOP-encoding constant shared with the pipeline registers.
REQ-032 Busy down-counter SHALL be a sub-module hazard_busy_cnt (load, decrement, last flag); lu compare stays inline.

Verification
REQ-033 ex_mem_read=1, ex_rd=5, id_rt=5, id_uses_rt=1 -> pc_stall=ifid_stall=idex_bubble=1 for one cycle; same with id_uses_rt=0 -> all 0.
REQ-034 Same inputs as REQ-033 plus ex_branch_taken=1 -> ifid_flush=idex_bubble=1, pc_stall=0.
REQ-035 MUL_CYCLES=4, id_is_mul=1 for one cycle -> mul_start pulse, then busy=ex_hold=pc_stall=1 for exactly 3 cycles, then RUN.
REQ-036 id_is_mul held high for 2 multiplies -> mul_start at cycle 0 and cycle 4, busy in cycles 1-3 and 5-7.
REQ-037 rst_n dropped in the 2nd MUL_BUSY cycle -> all outputs 0 asynchronously; after release, busy=0.
REQ-038 HAZARD_PERF_EN defined: 1 load-use stall plus 1 multiply with MUL_CYCLES=4 -> stall_cnt=4.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, hazard FSM states,
// busy-counter width and the NOP encoding loaded into flushed/bubbled stages.
package pipe_pkg;

  localparam int REG_AW = 4;
  localparam int CNT_W  = 4;

  // addi x0, x0, 0 -- the canonical NOP used by the IF/ID and ID/EX registers.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/hazard_busy_cnt.sv
// Down-counter tracking the remaining multiplier cycles; last flags the final busy cycle.
module hazard_busy_cnt
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle multiply hold.
// Optional HAZARD_PERF_EN adds a saturating stall_cnt output counting pc_stall cycles.
module hazard_ctrl #(
  parameter int REG_AW     = pipe_pkg::REG_AW,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_mul,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              ex_hold,
  output logic              mul_start,
  output logic              busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  pipe_pkg::hazard_state_t state_reg, state_next;

  logic lu;
  logic cnt_load, cnt_dec, cnt_last;
  logic pc_stall_c, ifid_stall_c, idex_bubble_c, ifid_flush_c;
  logic ex_hold_c, mul_start_c, busy_c;

  assign lu = ex_mem_read & ((id_uses_rs & (id_rs == ex_rd)) |
                             (id_uses_rt & (id_rt == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= pipe_pkg::RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    idex_bubble_c = 1'b0;
    ifid_flush_c  = 1'b0;
    ex_hold_c     = 1'b0;
    mul_start_c   = 1'b0;
    busy_c        = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    case (state_reg)
      pipe_pkg::RUN: begin
        if (ex_branch_taken) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (lu) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (id_is_mul) begin
          mul_start_c = 1'b1;
          cnt_load    = 1'b1;
          state_next  = pipe_pkg::MUL_BUSY;
        end
      end
      pipe_pkg::MUL_BUSY: begin
        // EX-side inputs are frozen behind the multiplier, so they are not looked at here.
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        ex_hold_c    = 1'b1;
        busy_c       = 1'b1;
        cnt_dec      = 1'b1;
        if (cnt_last) begin
          state_next = pipe_pkg::RUN;
        end
      end
      default: state_next = pipe_pkg::RUN;
    endcase
  end

  hazard_busy_cnt u_busy_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (pipe_pkg::CNT_W'(MUL_CYCLES - 1)),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // Outputs are Mealy, so reset must gate them directly to force zeros immediately.
  assign pc_stall    = rst_n & pc_stall_c;
  assign ifid_stall  = rst_n & ifid_stall_c;
  assign idex_bubble = rst_n & idex_bubble_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign ex_hold     = rst_n & ex_hold_c;
  assign mul_start   = rst_n & mul_start_c;
  assign busy        = rst_n & busy_c;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (pc_stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
